// File: rtl/keyscan_pkg.sv
// rtl/keyscan_pkg.sv - shared keypad geometry and scanner state encoding
package keyscan_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } scanstate_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with row debounce and press freeze
module keypad_scan
  import keyscan_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_ROWS-1:0]          rows_n,
  output logic [NUM_COLS-1:0]          cols_n,
  output logic [NUM_ROWS+NUM_COLS-1:0] rcBits
);

  localparam int DWELL_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W   = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]   CNT_PENULT = CNT_W'(DEBOUNCE - 2);

  logic [NUM_ROWS-1:0] rows_q;
  logic [NUM_ROWS-1:0] rows_s;

  scanstate_t          state, state_nxt;
  logic [DWELL_W-1:0]  dwell, dwell_nxt;
  logic [CNT_W-1:0]    deb_cnt, deb_nxt;
  logic [CNT_W-1:0]    rel_cnt, rel_nxt;
  logic [NUM_ROWS-1:0] cap, cap_nxt;
  logic [NUM_ROWS-1:0] pub, pub_nxt;
  logic [NUM_COLS-1:0] col_oh, col_oh_nxt;

  sync_2ff #(
    .WIDTH     (NUM_ROWS),
    .RESET_VAL ({NUM_ROWS{1'b1}})
  ) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows_n),
    .q     (rows_q)
  );

  assign rows_s = ~rows_q;
  assign rcBits = {pub, col_oh};

  // State, counters, captured pattern and column drive registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      dwell   <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      cap     <= '0;
      pub     <= '0;
      col_oh  <= NUM_COLS'(1);
      cols_n  <= ~NUM_COLS'(1);
    end else begin
      state   <= state_nxt;
      dwell   <= dwell_nxt;
      deb_cnt <= deb_nxt;
      rel_cnt <= rel_nxt;
      cap     <= cap_nxt;
      pub     <= pub_nxt;
      col_oh  <= col_oh_nxt;
      cols_n  <= ~col_oh_nxt;
    end
  end

  // Scan/debounce/hold sequencing; the column only ever moves on a quiet SCAN tick
  always_comb begin
    state_nxt  = state;
    dwell_nxt  = dwell;
    deb_nxt    = deb_cnt;
    rel_nxt    = rel_cnt;
    cap_nxt    = cap;
    pub_nxt    = pub;
    col_oh_nxt = col_oh;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (rows_s == '0) begin
            col_oh_nxt = {col_oh[NUM_COLS-2:0], col_oh[NUM_COLS-1]};
          end else begin
            cap_nxt   = rows_s;
            deb_nxt   = '0;
            state_nxt = DEB;
          end
        end else begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      DEB: begin
        if (rows_s == cap) begin
          deb_nxt = deb_cnt + 1'b1;
          if (deb_cnt == CNT_PENULT) begin
            state_nxt = HELD;
            pub_nxt   = cap;
            rel_nxt   = '0;
          end
        end else begin
          // Bounce: retry the same column with a fresh dwell
          state_nxt = SCAN;
          dwell_nxt = '0;
        end
      end
      HELD: begin
        if (rows_s == '0) begin
          if (rel_cnt == CNT_LAST) begin
            state_nxt = SCAN;
            pub_nxt   = '0;
            dwell_nxt = '0;
            rel_nxt   = '0;
          end else begin
            rel_nxt = rel_cnt + 1'b1;
          end
        end else begin
          rel_nxt = '0;
        end
      end
      default: begin
        state_nxt = SCAN;
        dwell_nxt = '0;
        pub_nxt   = '0;
      end
    endcase
  end

endmodule
